// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants for the instruction/data memory port arbiter: funct3 load/store
// codes and the memory-mapped UART / hardware-counter addresses.
package mem_port_arbiter_pkg;

  localparam logic [2:0] LOAD_LB  = 3'b000;
  localparam logic [2:0] LOAD_LH  = 3'b001;
  localparam logic [2:0] LOAD_LW  = 3'b010;
  localparam logic [2:0] LOAD_LBU = 3'b100;
  localparam logic [2:0] LOAD_LHU = 3'b101;

  localparam logic [2:0] STORE_SB = 3'b000;
  localparam logic [2:0] STORE_SH = 3'b001;
  localparam logic [2:0] STORE_SW = 3'b010;

  localparam logic [31:0] UART_TX_ADDR          = 32'h8000_0000;
  localparam logic [31:0] HARDWARE_COUNTER_ADDR = 32'h8000_0004;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Core-side (fetch, load/store, UART, counter) and memory-side signals of the arbiter.
// master = core pipeline plus memory macro environment, slave = the arbiter.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 16
);
  logic              i_req;
  logic [31:0]       i_addr;
  logic              i_gnt;
  logic              i_rvalid;
  logic [31:0]       i_rdata;

  logic              d_req;
  logic              d_we;
  logic [31:0]       d_addr;
  logic [2:0]        d_type;
  logic [31:0]       d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [31:0]       d_rdata;
  logic              d_err;

  logic [31:0]       hw_counter;
  logic              uart_busy;
  logic              uart_we;
  logic [7:0]        uart_data;

  logic              mem_en;
  logic [3:0]        mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_type, d_wdata,
           hw_counter, uart_busy, mem_rdata,
    input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata, d_err,
           uart_we, uart_data, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_type, d_wdata,
           hw_counter, uart_busy, mem_rdata,
    output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata, d_err,
           uart_we, uart_data, mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_lane_format.sv
// Byte-lane formatting: store strobes/lane shift and alignment check on the request
// side, load extract and sign/zero extension on the response side.
module mem_lane_format
  import mem_port_arbiter_pkg::*;
(
  input  logic        req_we,
  input  logic [2:0]  req_type,
  input  logic [1:0]  req_off,
  input  logic [31:0] req_wdata,
  output logic [3:0]  wr_strb,
  output logic [31:0] wr_data,
  output logic        misal,
  input  logic [2:0]  rsp_type,
  input  logic [1:0]  rsp_off,
  input  logic [31:0] rsp_raw,
  output logic [31:0] rsp_data
);

  logic [31:0] rsp_shifted;

  // Unknown store types fall through to the word path.
  always_comb begin
    wr_strb = 4'b1111;
    wr_data = req_wdata;
    case (req_type)
      STORE_SB: begin
        wr_strb = 4'b0001 << req_off;
        wr_data = {4{req_wdata[7:0]}};
      end
      STORE_SH: begin
        wr_strb = 4'b0011 << req_off;
        wr_data = req_wdata << {req_off, 3'b000};
      end
      default: ;
    endcase
  end

  always_comb begin
    misal = 1'b0;
    if (req_we) begin
      case (req_type)
        STORE_SB: misal = 1'b0;
        STORE_SH: misal = (req_off == 2'd3);
        default:  misal = (req_off != 2'd0);
      endcase
    end else begin
      case (req_type)
        LOAD_LH, LOAD_LHU: misal = (req_off == 2'd3);
        LOAD_LW:           misal = (req_off != 2'd0);
        default:           misal = 1'b0;
      endcase
    end
  end

  assign rsp_shifted = rsp_raw >> {rsp_off, 3'b000};

  always_comb begin
    case (rsp_type)
      LOAD_LB:  rsp_data = {{24{rsp_shifted[7]}}, rsp_shifted[7:0]};
      LOAD_LH:  rsp_data = {{16{rsp_shifted[15]}}, rsp_shifted[15:0]};
      LOAD_LW:  rsp_data = rsp_shifted;
      LOAD_LBU: rsp_data = {24'd0, rsp_shifted[7:0]};
      LOAD_LHU: rsp_data = {16'd0, rsp_shifted[15:0]};
      default:  rsp_data = rsp_raw;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous-read memory between instruction fetch and the load/store
// unit, with starvation protection for fetch, a UART TX store path and a counter load.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W       = 16,
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input logic               clk,
  input logic               rst_n,
  mem_port_arbiter_if.slave bus
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic             is_uart_p0;
  logic             is_cnt_p0;
  logic             uart_stall_p0;
  logic             i_force_p0;
  logic             d_gnt_p0;
  logic             i_gnt_p0;
  logic             d_mem_p0;
  logic             misal_p0;
  logic [3:0]       wr_strb_p0;
  logic [31:0]      wr_data_p0;
  logic [CNT_W-1:0] starve_cnt;
  logic [CNT_W-1:0] starve_cnt_nxt;

  logic             vld_i_p1;
  logic             vld_d_p1;
  logic             err_p1;
  logic             ld_p1;
  logic             cnt_sel_p1;
  logic [31:0]      cnt_p1;
  logic [2:0]       type_p1;
  logic [1:0]       off_p1;
  logic [31:0]      ld_data_p1;

  logic             unused_addr;
  assign unused_addr = ^{bus.i_addr[31:ADDR_W+2], bus.i_addr[1:0]};

  mem_lane_format u_fmt (
    .req_we    (bus.d_we),
    .req_type  (bus.d_type),
    .req_off   (bus.d_addr[1:0]),
    .req_wdata (bus.d_wdata),
    .wr_strb   (wr_strb_p0),
    .wr_data   (wr_data_p0),
    .misal     (misal_p0),
    .rsp_type  (type_p1),
    .rsp_off   (off_p1),
    .rsp_raw   (bus.mem_rdata),
    .rsp_data  (ld_data_p1)
  );

  // ---- p0: request decode and combinational grant ----
  assign is_uart_p0    = bus.d_we && (bus.d_addr == UART_TX_ADDR);
  assign is_cnt_p0     = !bus.d_we && (bus.d_type == LOAD_LW) &&
                         (bus.d_addr == HARDWARE_COUNTER_ADDR);
  assign uart_stall_p0 = bus.d_req && is_uart_p0 && bus.uart_busy;
  assign i_force_p0    = bus.i_req && (starve_cnt == LIMIT);
  // Grants are masked while reset is asserted so nothing reaches the memory.
  assign d_gnt_p0      = rst_n && bus.d_req && !uart_stall_p0 && !i_force_p0;
  assign i_gnt_p0      = rst_n && bus.i_req && !d_gnt_p0;
  assign d_mem_p0      = d_gnt_p0 && !is_uart_p0 && !is_cnt_p0 && !misal_p0;

  // A fetch granted only because the UART stalled D does not reset the count.
  always_comb begin
    starve_cnt_nxt = starve_cnt;
    if (!bus.i_req) begin
      starve_cnt_nxt = '0;
    end else if (d_gnt_p0) begin
      if (starve_cnt != LIMIT) starve_cnt_nxt = starve_cnt + CNT_W'(1);
    end else if (i_gnt_p0 && !uart_stall_p0) begin
      starve_cnt_nxt = '0;
    end
  end

  assign bus.i_gnt     = i_gnt_p0;
  assign bus.d_gnt     = d_gnt_p0;
  assign bus.mem_en    = i_gnt_p0 || d_mem_p0;
  assign bus.mem_we    = (d_mem_p0 && bus.d_we) ? wr_strb_p0 : 4'b0000;
  assign bus.mem_addr  = i_gnt_p0 ? bus.i_addr[ADDR_W+1:2] : bus.d_addr[ADDR_W+1:2];
  assign bus.mem_wdata = wr_data_p0;
  assign bus.uart_we   = d_gnt_p0 && is_uart_p0;
  assign bus.uart_data = bus.d_wdata[7:0];

  // ---- p1: response stage ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
      vld_i_p1   <= 1'b0;
      vld_d_p1   <= 1'b0;
      err_p1     <= 1'b0;
    end else begin
      starve_cnt <= starve_cnt_nxt;
      vld_i_p1   <= i_gnt_p0;
      vld_d_p1   <= d_gnt_p0;
      err_p1     <= d_gnt_p0 && misal_p0 && !is_uart_p0;
    end
  end

  always_ff @(posedge clk) begin
    ld_p1      <= d_mem_p0 && !bus.d_we;
    cnt_sel_p1 <= d_gnt_p0 && is_cnt_p0;
    cnt_p1     <= bus.hw_counter;
    type_p1    <= bus.d_type;
    off_p1     <= bus.d_addr[1:0];
  end

  always_comb begin
    bus.d_rdata = '0;
    if (cnt_sel_p1)  bus.d_rdata = cnt_p1;
    else if (ld_p1)  bus.d_rdata = ld_data_p1;
  end

  assign bus.i_rvalid = vld_i_p1;
  assign bus.i_rdata  = bus.mem_rdata;
  assign bus.d_rvalid = vld_d_p1;
  assign bus.d_err    = err_p1;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: memory macro model, byte-level reference memory and
// transaction-level arbitration model; directed scenarios followed by random traffic.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int ADDR_W       = 16;
  localparam int STARVE_LIMIT = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

  mem_port_arbiter #(.ADDR_W(ADDR_W), .STARVE_LIMIT(STARVE_LIMIT), .CNT_W(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Synchronous-read memory macro (256 words), writes land at the clock edge.
  logic [31:0] macro_mem [0:255];
  always @(posedge clk) begin
    if (bus.mem_en) begin
      bus.mem_rdata <= macro_mem[bus.mem_addr[7:0]];
      for (int b = 0; b < 4; b++)
        if (bus.mem_we[b]) macro_mem[bus.mem_addr[7:0]][8*b +: 8] = bus.mem_wdata[8*b +: 8];
    end
  end

  logic [7:0]  ref_mem [0:1023];
  int          checks = 0;
  int          failures = 0;
  int          scnt = 0;
  int          uart_strobes = 0;
  logic        pend_i = 0, pend_d = 0, pend_ld = 0, pend_err = 0;
  logic [31:0] pend_i_data = 0, pend_data = 0;
  logic        d_granted = 0, i_granted = 0;
  logic        last_dut_d = 0, last_dut_i = 0;
  logic [2:0]  ld_types [0:5];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input logic [31:0] addr);
    int a;
    a = int'({addr[9:2], 2'b00});
    return {ref_mem[a+3], ref_mem[a+2], ref_mem[a+1], ref_mem[a]};
  endfunction

  function automatic logic misaligned(input logic we, input logic [2:0] t, input logic [1:0] off);
    if (we) return (t == STORE_SB) ? 1'b0 : (t == STORE_SH) ? (off == 2'd3) : (off != 2'd0);
    if (t == LOAD_LH || t == LOAD_LHU) return off == 2'd3;
    if (t == LOAD_LW) return off != 2'd0;
    return 1'b0;
  endfunction

  function automatic logic [31:0] load_value(input logic [2:0] t, input logic [31:0] addr);
    int a;
    logic [15:0] h;
    a = int'(addr[9:0]);
    case (t)
      LOAD_LB:  return {{24{ref_mem[a][7]}}, ref_mem[a]};
      LOAD_LBU: return {24'd0, ref_mem[a]};
      LOAD_LH:  begin h = {ref_mem[a+1], ref_mem[a]}; return {{16{h[15]}}, h}; end
      LOAD_LHU: begin h = {ref_mem[a+1], ref_mem[a]}; return {16'd0, h}; end
      default:  return ref_word(addr);
    endcase
  endfunction

  // One clock: check last cycle's responses, then this cycle's grants and memory controls.
  task automatic cycle();
    logic       ed, ei, stall, uart, cnt, mis, exp_en;
    logic [3:0] exp_we;
    int         a;
    @(negedge clk);
    check("i_rvalid", 32'(bus.i_rvalid), 32'(pend_i));
    if (pend_i) check("i_rdata", bus.i_rdata, pend_i_data);
    check("d_rvalid", 32'(bus.d_rvalid), 32'(pend_d));
    if (pend_d) begin
      check("d_err", 32'(bus.d_err), 32'(pend_err));
      if (pend_ld) check("d_rdata", bus.d_rdata, pend_data);
    end
    uart  = bus.d_we && (bus.d_addr == UART_TX_ADDR);
    cnt   = !bus.d_we && (bus.d_type == LOAD_LW) && (bus.d_addr == HARDWARE_COUNTER_ADDR);
    stall = bus.d_req && uart && bus.uart_busy;
    ed    = bus.d_req && !stall && !(bus.i_req && scnt == STARVE_LIMIT);
    ei    = bus.i_req && !ed;
    last_dut_d = bus.d_gnt;
    last_dut_i = bus.i_gnt;
    check("d_gnt", 32'(bus.d_gnt), 32'(ed));
    check("i_gnt", 32'(bus.i_gnt), 32'(ei));
    if (bus.uart_we) uart_strobes++;
    check("uart_we", 32'(bus.uart_we), 32'(ed && uart));
    pend_i = ei; pend_d = ed; pend_ld = 1'b0; pend_err = 1'b0;
    exp_en = ei; exp_we = 4'd0;
    if (ei) begin
      pend_i_data = ref_word(bus.i_addr);
      check("mem_addr_i", 32'(bus.mem_addr), 32'(bus.i_addr[17:2]));
    end
    if (ed) begin
      a   = int'(bus.d_addr[9:0]);
      mis = misaligned(bus.d_we, bus.d_type, bus.d_addr[1:0]);
      if (uart) begin
        check("uart_data", 32'(bus.uart_data), 32'(bus.d_wdata[7:0]));
      end else if (cnt) begin
        pend_ld = 1'b1; pend_data = bus.hw_counter;
      end else if (mis) begin
        pend_err = 1'b1; pend_ld = !bus.d_we; pend_data = 32'd0;
      end else begin
        exp_en = 1'b1;
        check("mem_addr_d", 32'(bus.mem_addr), 32'(bus.d_addr[17:2]));
        if (bus.d_we) begin
          case (bus.d_type)
            STORE_SB: begin
              exp_we = 4'(1 << bus.d_addr[1:0]);
              ref_mem[a] = bus.d_wdata[7:0];
            end
            STORE_SH: begin
              exp_we = 4'(3 << bus.d_addr[1:0]);
              ref_mem[a] = bus.d_wdata[7:0]; ref_mem[a+1] = bus.d_wdata[15:8];
            end
            default: begin
              exp_we = 4'hF;
              for (int b = 0; b < 4; b++) ref_mem[a+b] = bus.d_wdata[8*b +: 8];
            end
          endcase
        end else begin
          pend_ld = 1'b1; pend_data = load_value(bus.d_type, bus.d_addr);
        end
      end
    end
    check("mem_en", 32'(bus.mem_en), 32'(exp_en));
    check("mem_we", 32'(bus.mem_we), 32'(exp_we));
    if (!bus.i_req) scnt = 0;
    else if (ed) scnt = (scnt < STARVE_LIMIT) ? scnt + 1 : scnt;
    else if (ei && !stall) scnt = 0;
    d_granted = ed; i_granted = ei;
    @(posedge clk); #1;
    bus.hw_counter = bus.hw_counter + 32'd1;
  endtask

  task automatic set_d(input logic we, input logic [31:0] addr, input logic [2:0] t,
                       input logic [31:0] wd);
    bus.d_req = 1'b1; bus.d_we = we; bus.d_addr = addr; bus.d_type = t; bus.d_wdata = wd;
  endtask

  task automatic do_d(input logic we, input logic [31:0] addr, input logic [2:0] t,
                      input logic [31:0] wd);
    set_d(we, addr, t, wd);
    for (int k = 0; k < 20; k++) begin
      cycle();
      if (d_granted) break;
    end
    check("d_gnt_wait", 32'(last_dut_d), 32'd1);
    bus.d_req = 1'b0;
  endtask

  task automatic rand_d();
    int r;
    r = int'($urandom_range(0, 19));
    if (r == 0)      set_d(1'b1, UART_TX_ADDR, STORE_SW, $urandom);
    else if (r == 1) set_d(1'b0, HARDWARE_COUNTER_ADDR, LOAD_LW, $urandom);
    else if (r < 10) set_d(1'b1, 32'($urandom_range(0, 1023)), 3'($urandom_range(0, 2)), $urandom);
    else             set_d(1'b0, 32'($urandom_range(0, 1023)), ld_types[$urandom_range(0, 5)], $urandom);
  endtask

  initial begin
    ld_types[0] = LOAD_LB; ld_types[1] = LOAD_LH; ld_types[2] = LOAD_LW;
    ld_types[3] = LOAD_LBU; ld_types[4] = LOAD_LHU; ld_types[5] = 3'b011;
    for (int w = 0; w < 256; w++) begin
      logic [31:0] v;
      v = (w == 'h40) ? 32'h1122_3344 : $urandom;
      macro_mem[w] = v;
      for (int b = 0; b < 4; b++) ref_mem[4*w+b] = v[8*b +: 8];
    end
    rst_n = 1'b0;
    bus.i_req = 1'b0; bus.i_addr = 32'd0; bus.d_req = 1'b0; bus.d_we = 1'b0;
    bus.d_addr = 32'd0; bus.d_type = 3'd0; bus.d_wdata = 32'd0;
    bus.hw_counter = 32'd0; bus.uart_busy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_i_rvalid", 32'(bus.i_rvalid), 32'd0);
    check("rst_d_rvalid", 32'(bus.d_rvalid), 32'd0);
    check("rst_d_err", 32'(bus.d_err), 32'd0);
    check("rst_mem_en", 32'(bus.mem_en), 32'd0);
    rst_n = 1'b1;

    // Reset arriving the cycle after a granted load drops its response.
    do_d(1'b0, 32'h100, LOAD_LW, 32'd0);
    rst_n = 1'b0;
    bus.i_req = 1'b1;
    #1;
    check("rst_mid_d_rvalid", 32'(bus.d_rvalid), 32'd0);
    check("rst_mid_mem_we", 32'(bus.mem_we), 32'd0);
    check("rst_mid_mem_en", 32'(bus.mem_en), 32'd0);
    check("rst_mid_uart_we", 32'(bus.uart_we), 32'd0);
    check("rst_mid_i_gnt", 32'(bus.i_gnt), 32'd0);
    pend_i = 1'b0; pend_d = 1'b0; scnt = 0;
    bus.i_req = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    do_d(1'b1, 32'h103, STORE_SB, 32'h0000_00A5);
    do_d(1'b0, 32'h100, LOAD_LW, 32'd0);
    check("sb_then_lw", bus.d_rdata, 32'hA522_3344);
    do_d(1'b1, 32'h102, STORE_SH, 32'h0000_BEEF);
    do_d(1'b0, 32'h102, LOAD_LHU, 32'd0);
    check("sh_then_lhu", bus.d_rdata, 32'h0000_BEEF);
    do_d(1'b0, 32'h102, LOAD_LH, 32'd0);
    check("sh_then_lh", bus.d_rdata, 32'hFFFF_BEEF);

    do_d(1'b1, 32'h101, STORE_SW, 32'hDEAD_BEEF);
    check("mis_sw_err", 32'(bus.d_err), 32'd1);
    do_d(1'b0, 32'h103, LOAD_LH, 32'd0);
    check("mis_lh_err", 32'(bus.d_err), 32'd1);
    check("mis_lh_data", bus.d_rdata, 32'd0);

    uart_strobes = 0;
    bus.i_req = 1'b1; bus.i_addr = 32'h200; bus.uart_busy = 1'b1;
    set_d(1'b1, UART_TX_ADDR, STORE_SW, 32'h0000_0041);
    repeat (3) begin
      cycle();
      check("uart_busy_no_dgnt", 32'(last_dut_d), 32'd0);
      check("uart_busy_igrant", 32'(last_dut_i), 32'd1);
    end
    bus.uart_busy = 1'b0;
    cycle();
    check("uart_free_dgnt", 32'(last_dut_d), 32'd1);
    bus.d_req = 1'b0; bus.i_req = 1'b0;
    cycle(); cycle();
    check("uart_once", 32'(uart_strobes), 32'd1);

    set_d(1'b0, HARDWARE_COUNTER_ADDR, LOAD_LW, 32'd0);
    bus.hw_counter = 32'h0000_1234;
    do_d(1'b0, HARDWARE_COUNTER_ADDR, LOAD_LW, 32'd0);
    check("counter_load", bus.d_rdata, 32'h0000_1234);
    cycle();

    // Both ports saturated: expected D,D,D,D,I repeating from a cleared count.
    bus.i_req = 1'b1; bus.i_addr = 32'h0000_0040;
    set_d(1'b0, 32'h0000_0080, LOAD_LW, 32'd0);
    for (int k = 0; k < 15; k++) begin
      cycle();
      check("contend_d_seq", 32'(last_dut_d), 32'((k % 5) != 4));
      if (d_granted) bus.d_addr = {22'd0, 8'($urandom), 2'b00};
      if (i_granted) bus.i_addr = {22'd0, 8'($urandom), 2'b00};
    end
    bus.i_req = 1'b0; bus.d_req = 1'b0;
    cycle();

    repeat (600) begin
      if (d_granted || !bus.d_req) begin
        bus.d_req = 1'b0;
        if ($urandom_range(0, 3) != 0) rand_d();
      end
      if (i_granted || !bus.i_req) begin
        bus.i_req = 1'b0;
        if ($urandom_range(0, 2) != 0) begin
          bus.i_req = 1'b1; bus.i_addr = {22'd0, 8'($urandom), 2'b00};
        end
      end
      bus.uart_busy = ($urandom_range(0, 2) == 0);
      cycle();
    end
    bus.d_req = 1'b0; bus.i_req = 1'b0;
    repeat (2) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
